difftest_arch_event_queue: RTL and testbench
============================================

Name: difftest_arch_event_queue

Overview:
- Multi-channel, buffered successor to the single-core architectural event probe.
- Captures interrupt/exception events from NUM_CH commit channels, one per core or commit port, and arbitrates them round-robin into a shared FIFO.
- Presents events one at a time on a valid/ready interface to the difftest collector, stamped with channel id and a global sequence number.
- Counts events lost to back-pressure instead of stalling the core.

Parameters:
- NUM_CH, 2, number of input channels (1..8).
- DEPTH, 8, shared FIFO entries; power of two, at least 2.
- CAUSE_W, 32, width of the interrupt and exception cause fields.
- PC_W, 64, exception PC width.
- INST_W, 32, exception instruction width.
- CORE_W, 8, core id width.
- SEQ_W, 16, sequence counter width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_CH  per-channel event strobe.
- in_interrupt  in  NUM_CH*CAUSE_W  per-channel interrupt cause; channel i occupies bits [i*CAUSE_W +: CAUSE_W].
- in_exception  in  NUM_CH*CAUSE_W  per-channel exception cause, same packing.
- in_pc  in  NUM_CH*PC_W  per-channel exception PC, same packing.
- in_inst  in  NUM_CH*INST_W  per-channel exception instruction, same packing.
- in_coreid  in  NUM_CH*CORE_W  per-channel core id, same packing.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head.
- out_chan  out  3  source channel index.
- out_interrupt  out  CAUSE_W  head interrupt cause.
- out_exception  out  CAUSE_W  head exception cause.
- out_pc  out  PC_W  head exception PC.
- out_inst  out  INST_W  head exception instruction.
- out_coreid  out  CORE_W  head core id.
- out_seq  out  SEQ_W  sequence number of head.
- occupancy  out  clog2(DEPTH)+1  FIFO fill level.
- drop_count  out  16  saturating count of lost events.

Behaviour:
- Reset (reset low, asynchronous):
  - All pending registers and the FIFO are emptied.
  - Round-robin pointer, sequence counter, occupancy and drop_count go to 0.
  - out_valid = 0; all out_* payload fields = 0.
- Stage 1, pending registers:
  - Each channel has one pending register.
  - in_valid[i] at an edge loads channel i's payload into its pending register and sets it full.
- Stage 2, arbitration:
  - Each cycle at most one full pending register is granted.
  - Search order: round-robin starting at rr_ptr; after a grant of channel g, rr_ptr = (g+1) mod NUM_CH.
  - A grant happens only if the FIFO is not full, or a pop occurs in the same cycle.
  - The granted entry is pushed at the edge and its pending register is cleared, unless it is reloaded by a simultaneous in_valid.
- Drop rule:
  - in_valid[i] while pending[i] is full and not granted that cycle discards the new event; pending keeps the old one.
  - drop_count increments by 1 per dropped event, saturating at 0xFFFF.
  - Multiple channels dropping in the same cycle add their total, still saturating.
- Simultaneous grant and reload: pending[i] granted while in_valid[i] is high is overwritten with the new event and stays full. No drop.
- Sequence numbering: each push stamps the current seq counter value, then the counter increments, wrapping mod 2^SEQ_W.
- Latency: in_valid asserted in cycle t gives out_valid in cycle t+2 at the earliest, when the FIFO is empty and there is no contention.
- Output side:
  - Pop occurs when out_valid and out_ready are both high.
  - Payload is stable while out_valid is high and out_ready is low.
  - out_* fields read 0 when the FIFO is empty.
- Push and pop in the same cycle:
  - Occupancy is unchanged.
  - When full, a push is permitted only alongside a pop.
- Pointers: read and write pointers wrap mod DEPTH. Full is occupancy == DEPTH; empty is occupancy == 0.
- out_ready high while empty is a no-op.

Test Plan:
- Single event: channel 0 pulses in_valid with exception=2, pc=0x80000010, inst=0x00000073, coreid=0. Required: out_valid rises 2 cycles later with out_chan=0, out_seq=0; drop_count stays 0.
- Contention: both channels pulse in the same cycle, out_ready=1. Required: channel 0 emerges with seq 0, then channel 1 with seq 1 on consecutive cycles; the next simultaneous pair emerges channel 0 first again, per the rr_ptr rule.
- Fill and back-pressure: out_ready=0, channel 0 pulses every cycle for 12 cycles. Required: occupancy reaches 8; pending holds 1 event; drop_count = 3.
- Full with simultaneous push/pop: FIFO full, pending[0] full, out_ready=1 for one cycle. Required: occupancy stays 8; the head advances to the next seq; pending[0] is cleared.
- Wrap and saturation:
  - Push 2^16+3 events. Required: seq wraps, and the last out_seq = 2.
  - Force more than 65535 drops. Required: drop_count holds 0xFFFF.
- Reset mid-operation: assert reset with the FIFO at 5 entries and out_valid high. Required: out_valid, occupancy and out_seq go to 0 immediately, without waiting for a clock edge; the first post-reset event gets seq 0.

Source files
------------

// File: rtl/difftest_arch_event_queue.sv
// Multi-channel architectural event queue: per-channel pending registers, round-robin
// arbitration into a shared FIFO, sequence stamping and saturating drop accounting.
module difftest_arch_event_queue #(
   parameter int unsigned NUM_CH  = 2,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned CAUSE_W = 32,
   parameter int unsigned PC_W    = 64,
   parameter int unsigned INST_W  = 32,
   parameter int unsigned CORE_W  = 8,
   parameter int unsigned SEQ_W   = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [NUM_CH-1:0]           in_valid,
   input  logic [NUM_CH*CAUSE_W-1:0]   in_interrupt,
   input  logic [NUM_CH*CAUSE_W-1:0]   in_exception,
   input  logic [NUM_CH*PC_W-1:0]      in_pc,
   input  logic [NUM_CH*INST_W-1:0]    in_inst,
   input  logic [NUM_CH*CORE_W-1:0]    in_coreid,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [2:0]                  out_chan,
   output logic [CAUSE_W-1:0]          out_interrupt,
   output logic [CAUSE_W-1:0]          out_exception,
   output logic [PC_W-1:0]             out_pc,
   output logic [INST_W-1:0]           out_inst,
   output logic [CORE_W-1:0]           out_coreid,
   output logic [SEQ_W-1:0]            out_seq,
   output logic [$clog2(DEPTH):0]      occupancy,
   output logic [15:0]                 drop_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [CAUSE_W-1:0] intr;
      logic [CAUSE_W-1:0] exc;
      logic [PC_W-1:0]    pc;
      logic [INST_W-1:0]  inst;
      logic [CORE_W-1:0]  core;
   } payload_t;

   typedef struct packed {
      logic [2:0]       chan;
      logic [SEQ_W-1:0] seq;
      payload_t         pay;
   } entry_t;

   payload_t             in_pay [NUM_CH];
   payload_t             pend_q [NUM_CH];
   payload_t             pend_d [NUM_CH];
   logic [NUM_CH-1:0]    pend_full_q, pend_full_d;
   logic [2:0]           rr_ptr_q;
   logic [SEQ_W-1:0]     seq_q;
   logic [15:0]          drop_q, drop_d;
   logic [3:0]           drop_inc;
   logic [16:0]          drop_sum;

   entry_t               mem_q [DEPTH];
   entry_t               head;
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]       count_q, count_d;

   logic                 grant_any, grant, push, pop, full, empty;
   logic [2:0]           grant_idx;
   payload_t             grant_pay;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
      assign in_pay[i].intr = in_interrupt[i*CAUSE_W +: CAUSE_W];
      assign in_pay[i].exc  = in_exception[i*CAUSE_W +: CAUSE_W];
      assign in_pay[i].pc   = in_pc[i*PC_W +: PC_W];
      assign in_pay[i].inst = in_inst[i*INST_W +: INST_W];
      assign in_pay[i].core = in_coreid[i*CORE_W +: CORE_W];
   end

   assign empty = (count_q == '0);
   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign pop   = !empty && out_ready;
   assign grant = grant_any && (!full || pop);
   assign push  = grant;

   // Pick the full channel at the smallest rotated distance from rr_ptr.
   always_comb begin
      int unsigned d;
      int unsigned best_d;
      grant_any = 1'b0;
      grant_idx = '0;
      grant_pay = '0;
      best_d    = NUM_CH;
      for (int unsigned j = 0; j < NUM_CH; j++) begin
         d = (j + NUM_CH - 32'(rr_ptr_q)) % NUM_CH;
         if (pend_full_q[j] && (d < best_d)) begin
            best_d    = d;
            grant_any = 1'b1;
            grant_idx = 3'(j);
            grant_pay = pend_q[j];
         end
      end
   end

   always_comb begin
      drop_inc    = '0;
      pend_full_d = pend_full_q;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         pend_d[i] = pend_q[i];
         if (in_valid[i]) begin
            if (!pend_full_q[i] || (grant && (grant_idx == 3'(i)))) begin
               pend_d[i]      = in_pay[i];
               pend_full_d[i] = 1'b1;
            end else begin
               drop_inc = drop_inc + 4'd1;
            end
         end else if (grant && (grant_idx == 3'(i))) begin
            pend_full_d[i] = 1'b0;
         end
      end
      drop_sum = {1'b0, drop_q} + 17'(drop_inc);
      drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
   end

   always_comb begin
      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            pend_q[i] <= '0;
         end
         pend_full_q <= '0;
         rr_ptr_q    <= '0;
         seq_q       <= '0;
         drop_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            pend_q[i] <= pend_d[i];
         end
         pend_full_q <= pend_full_d;
         drop_q      <= drop_d;
         count_q     <= count_d;
         if (grant) begin
            rr_ptr_q <= (grant_idx == 3'(NUM_CH - 1)) ? 3'd0 : grant_idx + 3'd1;
            seq_q    <= seq_q + 1'b1;
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   // Storage needs no reset: the head is masked while the FIFO is empty.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= '{chan: grant_idx, seq: seq_q, pay: grant_pay};
      end
   end

   always_comb begin
      head          = empty ? '0 : mem_q[rd_ptr_q];
      out_valid     = !empty;
      out_chan      = head.chan;
      out_seq       = head.seq;
      out_interrupt = head.pay.intr;
      out_exception = head.pay.exc;
      out_pc        = head.pay.pc;
      out_inst      = head.pay.inst;
      out_coreid    = head.pay.core;
      occupancy     = count_q;
      drop_count    = drop_q;
   end

endmodule

// File: tb/tb_difftest_arch_event_queue.sv
// Randomized and directed bench for difftest_arch_event_queue against a queue-based
// behavioural model of the pending/arbitration/FIFO rules.
module tb_difftest_arch_event_queue;

   localparam int NC    = 2;
   localparam int DEPTH = 8;

   logic          clock;
   logic          reset;
   logic [NC-1:0] in_valid;
   logic [NC*32-1:0] in_interrupt, in_exception, in_inst;
   logic [NC*64-1:0] in_pc;
   logic [NC*8-1:0]  in_coreid;
   logic          out_valid, out_ready;
   logic [2:0]    out_chan;
   logic [31:0]   out_interrupt, out_exception, out_inst;
   logic [63:0]   out_pc;
   logic [7:0]    out_coreid;
   logic [15:0]   out_seq;
   logic [3:0]    occupancy;
   logic [15:0]   drop_count;

   int n_checks = 0;
   int n_fail   = 0;

   difftest_arch_event_queue dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_interrupt  (in_interrupt),
      .in_exception  (in_exception),
      .in_pc         (in_pc),
      .in_inst       (in_inst),
      .in_coreid     (in_coreid),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_chan      (out_chan),
      .out_interrupt (out_interrupt),
      .out_exception (out_exception),
      .out_pc        (out_pc),
      .out_inst      (out_inst),
      .out_coreid    (out_coreid),
      .out_seq       (out_seq),
      .occupancy     (occupancy),
      .drop_count    (drop_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [2:0]  chan;
      logic [31:0] intr;
      logic [31:0] exc;
      logic [63:0] pc;
      logic [31:0] inst;
      logic [7:0]  core;
      logic [15:0] seq;
   } ev_t;

   ev_t q[$];
   ev_t m_pend [NC];
   bit  m_pend_v [NC];
   int  m_rr, m_seq, m_drop;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < NC; i++) begin
         m_pend_v[i] = 0;
         m_pend[i]   = '{default: '0};
      end
      m_rr = 0;
      m_seq = 0;
      m_drop = 0;
   endtask

   // One clock edge of the event queue's rules, using the inputs currently driven.
   task automatic model_step();
      bit pop;
      int g;
      ev_t e;
      pop = (q.size() > 0) && out_ready;
      g = -1;
      if (q.size() < DEPTH || pop) begin
         for (int k = 0; k < NC; k++) begin
            int idx;
            idx = (m_rr + k) % NC;
            if (g < 0 && m_pend_v[idx]) g = idx;
         end
      end
      if (pop) void'(q.pop_front());
      if (g >= 0) begin
         e = m_pend[g];
         e.seq = 16'(m_seq);
         q.push_back(e);
         m_seq = (m_seq + 1) % 65536;
         m_rr = (g + 1) % NC;
         m_pend_v[g] = 0;
      end
      for (int i = 0; i < NC; i++) begin
         if (in_valid[i]) begin
            if (m_pend_v[i]) begin
               if (m_drop < 65535) m_drop++;
            end else begin
               m_pend_v[i]    = 1;
               m_pend[i].chan = 3'(i);
               m_pend[i].intr = in_interrupt[i*32 +: 32];
               m_pend[i].exc  = in_exception[i*32 +: 32];
               m_pend[i].pc   = in_pc[i*64 +: 64];
               m_pend[i].inst = in_inst[i*32 +: 32];
               m_pend[i].core = in_coreid[i*8 +: 8];
               m_pend[i].seq  = '0;
            end
         end
      end
   endtask

   task automatic check_model();
      ev_t e;
      e = '{default: '0};
      if (q.size() > 0) e = q[0];
      check_eq("out_valid", out_valid, q.size() > 0);
      check_eq("occupancy", occupancy, q.size());
      check_eq("drop_count", drop_count, m_drop);
      check_eq("out_chan", out_chan, e.chan);
      check_eq("out_seq", out_seq, e.seq);
      check_eq("out_interrupt", out_interrupt, e.intr);
      check_eq("out_exception", out_exception, e.exc);
      check_eq("out_pc", out_pc, e.pc);
      check_eq("out_inst", out_inst, e.inst);
      check_eq("out_coreid", out_coreid, e.core);
   endtask

   task automatic rand_payload();
      for (int i = 0; i < NC; i++) begin
         in_interrupt[i*32 +: 32] = $urandom;
         in_exception[i*32 +: 32] = $urandom;
         in_pc[i*64 +: 64]        = {$urandom, $urandom};
         in_inst[i*32 +: 32]      = $urandom;
         in_coreid[i*8 +: 8]      = 8'($urandom);
      end
   endtask

   // Called at a falling edge: drive, advance model, clock once, check at next falling edge.
   task automatic tick(input logic [NC-1:0] vld, input logic rdy);
      in_valid  = vld;
      out_ready = rdy;
      model_step();
      @(posedge clock);
      @(negedge clock);
      check_model();
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      in_valid  = '0;
      out_ready = 1'b0;
      model_reset();
      #1;
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_occupancy", occupancy, 4'd0);
      check_eq("rst_seq", out_seq, 16'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check_model();
   endtask

   initial begin
      reset = 1'b0;
      in_valid = '0;
      out_ready = 1'b0;
      in_interrupt = '0;
      in_exception = '0;
      in_pc = '0;
      in_inst = '0;
      in_coreid = '0;
      do_reset();
      check_eq("rst_drop", drop_count, 16'd0);
      check_eq("rst_pc", out_pc, 64'd0);

      // Single event on channel 0
      in_exception[31:0] = 32'd2;
      in_pc[63:0]        = 64'h80000010;
      in_inst[31:0]      = 32'h00000073;
      tick(2'b01, 1'b0);
      check_eq("single_t1_valid", out_valid, 1'b0);
      tick(2'b00, 1'b0);
      check_eq("single_t2_valid", out_valid, 1'b1);
      check_eq("single_chan", out_chan, 3'd0);
      check_eq("single_seq", out_seq, 16'd0);
      check_eq("single_exc", out_exception, 32'd2);
      check_eq("single_pc", out_pc, 64'h80000010);
      check_eq("single_inst", out_inst, 32'h73);
      tick(2'b00, 1'b1);
      check_eq("single_drop", drop_count, 16'd0);

      // Contention and round-robin order
      do_reset();
      rand_payload();
      tick(2'b11, 1'b1);
      tick(2'b00, 1'b1);
      check_eq("cont_a_chan", out_chan, 3'd0);
      check_eq("cont_a_seq", out_seq, 16'd0);
      tick(2'b00, 1'b1);
      check_eq("cont_b_chan", out_chan, 3'd1);
      check_eq("cont_b_seq", out_seq, 16'd1);
      tick(2'b00, 1'b1);
      check_eq("cont_empty", out_valid, 1'b0);
      tick(2'b11, 1'b1);
      tick(2'b00, 1'b1);
      check_eq("cont_c_chan", out_chan, 3'd0);
      check_eq("cont_c_seq", out_seq, 16'd2);
      tick(2'b00, 1'b1);
      check_eq("cont_d_chan", out_chan, 3'd1);

      // Fill with back-pressure, then push/pop while full
      do_reset();
      for (int i = 0; i < 12; i++) begin
         rand_payload();
         tick(2'b01, 1'b0);
      end
      check_eq("fill_occ", occupancy, 4'd8);
      check_eq("fill_drop", drop_count, 16'd3);
      check_eq("fill_seq", out_seq, 16'd0);
      tick(2'b00, 1'b1);
      check_eq("fullpp_occ", occupancy, 4'd8);
      check_eq("fullpp_seq", out_seq, 16'd1);
      tick(2'b00, 1'b1);
      check_eq("fullpp_pend_clear", occupancy, 4'd7);
      check_eq("fullpp_seq2", out_seq, 16'd2);

      // Random traffic
      do_reset();
      for (int i = 0; i < 600; i++) begin
         rand_payload();
         tick(2'($urandom), (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end

      // Sequence wrap and drop saturation
      do_reset();
      rand_payload();
      for (int i = 0; i < 65540; i++) begin
         tick(2'b11, 1'b1);
      end
      check_eq("wrap_seq", out_seq, 16'd2);
      check_eq("sat_drop", drop_count, 16'hFFFF);
      tick(2'b11, 1'b1);
      check_eq("sat_hold", drop_count, 16'hFFFF);

      // Asynchronous reset mid-operation
      do_reset();
      for (int i = 0; i < 6; i++) begin
         rand_payload();
         tick(2'b01, 1'b0);
      end
      check_eq("mid_occ", occupancy, 4'd5);
      check_eq("mid_valid", out_valid, 1'b1);
      reset = 1'b0;
      in_valid = '0;
      out_ready = 1'b0;
      #1;
      check_eq("async_valid", out_valid, 1'b0);
      check_eq("async_occ", occupancy, 4'd0);
      check_eq("async_seq", out_seq, 16'd0);
      model_reset();
      #1;
      reset = 1'b1;
      @(negedge clock);
      rand_payload();
      tick(2'b10, 1'b0);
      tick(2'b00, 1'b0);
      check_eq("post_rst_valid", out_valid, 1'b1);
      check_eq("post_rst_chan", out_chan, 3'd1);
      check_eq("post_rst_seq", out_seq, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
